vec_elem_sequencer: RTL and testbench

// - Upstream stage of the 5:1 element operand mux. Accepts one vector op (vl, 3-bit operand select), then walks element indices 0..vl-1.
// - Issues synchronous register-file reads and streams element data + select to the mux/lane over a valid/ready handshake.
// - Absorbs lane backpressure against the 1-cycle read latency with a 2-entry skid buffer. Pulses done after the last element is accepted.

---
 rtl/vec_pkg.sv | 34 +++
 rtl/vec_skid_buf.sv | 67 ++++++
 rtl/vec_elem_sequencer.sv | 140 ++++++++++++++
 tb/tb_vec_elem_sequencer.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_pkg.sv
// Shared definitions for the vector element path: default widths, operand
// select encodings and the sequencer state type.
package vec_pkg;

    localparam int unsigned ELEN_DEFAULT = 32;
    localparam int unsigned IDXW_DEFAULT = 8;

    // I2..I4 ignore sel[0]; the constants give the canonical (bit 0 = 0) code.
    localparam logic [2:0] SEL_I0 = 3'b000;
    localparam logic [2:0] SEL_I1 = 3'b001;
    localparam logic [2:0] SEL_I2 = 3'b010;
    localparam logic [2:0] SEL_I3 = 3'b100;
    localparam logic [2:0] SEL_I4 = 3'b110;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_e;

    // Operand mux input number (0..4) selected by a 3-bit select code.
    function automatic logic [2:0] sel_to_input(input logic [2:0] sel);
        logic [2:0] res;
        casez (sel)
            3'b000:  res = 3'd0;
            3'b001:  res = 3'd1;
            3'b01?:  res = 3'd2;
            3'b10?:  res = 3'd3;
            default: res = 3'd4;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/vec_skid_buf.sv
// Two-entry FIFO that catches read data returning while the lane stalls.
// The head entry is presented combinationally; flush empties it synchronously.
module vec_skid_buf #(
    parameter int unsigned Width = 40
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [Width-1:0] push_data_i,
    input  logic             pop_i,
    output logic [Width-1:0] head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [1:0]       count_o
);

    logic [Width-1:0] mem_q [2];
    logic             rd_ptr_q;
    logic             wr_ptr_q;
    logic [1:0]       count_q;
    logic [1:0]       count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        count_d = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (flush_i) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/vec_elem_sequencer.sv
// Walks element indices of one vector op, issues register-file reads and streams
// the returned elements to the operand mux over valid/ready.
module vec_elem_sequencer
    import vec_pkg::*;
#(
    parameter int unsigned ELEN = vec_pkg::ELEN_DEFAULT,
    parameter int unsigned IDXW = vec_pkg::IDXW_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_valid,
    output logic            start_ready,
    input  logic [IDXW:0]   start_vl,
    input  logic [2:0]      start_sel,
    input  logic            flush,
    output logic            rf_rd_en,
    output logic [IDXW-1:0] rf_rd_idx,
    input  logic [ELEN-1:0] rf_rd_data,
    output logic            op_valid,
    input  logic            op_ready,
    output logic [ELEN-1:0] op_data,
    output logic [IDXW-1:0] op_idx,
    output logic [2:0]      op_sel,
    output logic            op_last,
    output logic            done
);

    localparam int unsigned BufW = ELEN + IDXW;

    state_e          state_q;
    logic [IDXW:0]   vl_q;
    logic [2:0]      sel_q;
    logic [IDXW:0]   iss_q;
    logic [IDXW:0]   acc_q;
    logic            inflight_q;
    logic [IDXW-1:0] inflight_idx_q;
    logic            done_q;

    logic [IDXW:0]   vl_last;
    logic [1:0]      credit;
    logic            pop;
    logic            buf_full;
    logic            buf_empty;
    logic [1:0]      buf_count;
    logic [BufW-1:0] buf_head;

    assign vl_last = vl_q - 1'b1;

    // A read may only issue if its data is guaranteed a slot on return.
    assign credit   = buf_count + {1'b0, inflight_q};
    assign rf_rd_en = (state_q == RUN) && (iss_q < vl_q) && (credit < 2'd2);
    assign rf_rd_idx = iss_q[IDXW-1:0];

    assign start_ready = (state_q == IDLE);
    assign op_valid    = !buf_empty;
    assign op_data     = buf_head[ELEN-1:0];
    assign op_idx      = buf_head[ELEN +: IDXW];
    assign op_sel      = sel_q;
    assign op_last     = op_valid && (acc_q == vl_last);
    assign done        = done_q;
    assign pop         = op_valid && op_ready;

    vec_skid_buf #(
        .Width (BufW)
    ) u_skid_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush),
        .push_i      (inflight_q),
        .push_data_i ({inflight_idx_q, rf_rd_data}),
        .pop_i       (pop),
        .head_o      (buf_head),
        .full_o      (buf_full),
        .empty_o     (buf_empty),
        .count_o     (buf_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            vl_q           <= '0;
            sel_q          <= '0;
            iss_q          <= '0;
            acc_q          <= '0;
            inflight_q     <= 1'b0;
            inflight_idx_q <= '0;
            done_q         <= 1'b0;
        end else if (flush) begin
            state_q        <= IDLE;
            vl_q           <= '0;
            iss_q          <= '0;
            acc_q          <= '0;
            inflight_q     <= 1'b0;
            inflight_idx_q <= '0;
            done_q         <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            inflight_q <= rf_rd_en;
            if (rf_rd_en) begin
                inflight_idx_q <= rf_rd_idx;
                iss_q          <= iss_q + 1'b1;
            end
            if (pop) begin
                acc_q <= acc_q + 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (start_valid) begin
                        vl_q  <= start_vl;
                        sel_q <= start_sel;
                        iss_q <= '0;
                        acc_q <= '0;
                        if (start_vl == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (rf_rd_en && (iss_q == vl_last)) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && op_last) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Credit rule must never let returning data meet a full buffer.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(inflight_q && buf_full && !pop));

endmodule

// File: tb/tb_vec_elem_sequencer.sv
// Directed bench for vec_elem_sequencer: a one-cycle RF model, a negedge beat
// monitor with an in-order scoreboard, and per-scenario expectations.
module tb_vec_elem_sequencer;

    localparam int ELEN = 32;
    localparam int IDXW = 8;

    logic            clk;
    logic            rst_n;
    logic            start_valid;
    logic            start_ready;
    logic [IDXW:0]   start_vl;
    logic [2:0]      start_sel;
    logic            flush;
    logic            rf_rd_en;
    logic [IDXW-1:0] rf_rd_idx;
    logic [ELEN-1:0] rf_rd_data;
    logic            op_valid;
    logic            op_ready;
    logic [ELEN-1:0] op_data;
    logic [IDXW-1:0] op_idx;
    logic [2:0]      op_sel;
    logic            op_last;
    logic            done;

    vec_elem_sequencer #(
        .ELEN (ELEN),
        .IDXW (IDXW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .start_vl    (start_vl),
        .start_sel   (start_sel),
        .flush       (flush),
        .rf_rd_en    (rf_rd_en),
        .rf_rd_idx   (rf_rd_idx),
        .rf_rd_data  (rf_rd_data),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .op_data     (op_data),
        .op_idx      (op_idx),
        .op_sel      (op_sel),
        .op_last     (op_last),
        .done        (done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int          cyc = 0;
    logic [31:0] rf_base = 32'h0;
    int          ready_mode = 0;
    int          stall_lo = 1000000;
    int          stall_hi = 0;

    // scoreboard state
    int          exp_vl = 0;
    int          exp_idx = 0;
    logic [2:0]  exp_sel = 3'b000;
    int          beat_cnt = 0;
    int          rd_cnt = 0;
    int          last_cnt = 0;
    int          done_cnt = 0;
    int          valid_cnt = 0;
    int          last_cyc = 0;
    int          done_cyc = 0;
    int          acc_cyc = 0;
    bit          prev_stall = 0;
    bit          prev_flush = 0;
    logic [IDXW-1:0] prev_idx = '0;
    logic [ELEN-1:0] prev_data = '0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Register file: data returns one cycle after the read strobe.
    always @(posedge clk) begin
        if (rf_rd_en) rf_rd_data <= rf_base + {24'b0, rf_rd_idx};
    end

    initial begin
        op_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       op_ready = 1'b1;
                1:       op_ready = 1'($urandom_range(0, 1));
                default: op_ready = !(cyc >= stall_lo && cyc <= stall_hi);
            endcase
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall && !prev_flush) begin
                check_eq("stall_valid", op_valid, 1'b1);
                check_eq("stall_idx", op_idx, prev_idx);
                check_eq("stall_data", op_data, prev_data);
            end
            if (rf_rd_en) begin
                rd_cnt++;
                check_eq("credit", (rd_cnt - beat_cnt) <= 2, 1);
            end
            if (op_valid) valid_cnt++;
            if (op_valid && op_ready) begin
                check_eq("op_idx", op_idx, exp_idx);
                check_eq("op_data", op_data, rf_base + exp_idx);
                check_eq("op_sel", op_sel, exp_sel);
                check_eq("op_last", op_last, exp_idx == exp_vl - 1);
                if (op_last) begin
                    last_cnt++;
                    last_cyc = cyc;
                end
                exp_idx++;
                beat_cnt++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            prev_stall = op_valid && !op_ready;
            prev_flush = flush;
            prev_idx   = op_idx;
            prev_data  = op_data;
        end else begin
            prev_stall = 0;
        end
    end

    task automatic clear_sb(input int vl, input logic [2:0] sel, input logic [31:0] base);
        exp_vl    = vl;
        exp_sel   = sel;
        rf_base   = base;
        exp_idx   = 0;
        beat_cnt  = 0;
        rd_cnt    = 0;
        last_cnt  = 0;
        done_cnt  = 0;
        valid_cnt = 0;
    endtask

    // Offer an op and return at posedge+1 of the first cycle after acceptance.
    task automatic do_start(input int vl, input logic [2:0] sel, input logic [31:0] base,
                            input bit hold);
        bit got = 0;
        clear_sb(vl, sel, base);
        @(posedge clk);
        #1;
        start_valid = 1'b1;
        start_vl    = vl[IDXW:0];
        start_sel   = sel;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (start_ready) begin
                got = 1;
                break;
            end
        end
        check_eq("start_accept", got, 1);
        @(posedge clk);
        #1;
        if (!hold) start_valid = 1'b0;
        acc_cyc = cyc;
    endtask

    task automatic wait_done(input int budget);
        bit got = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (done) begin
                got = 1;
                break;
            end
        end
        check_eq("done_seen", got, 1);
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_start_ready"}, start_ready, 1'b1);
        check_eq({tag, "_rf_rd_en"}, rf_rd_en, 1'b0);
        check_eq({tag, "_op_valid"}, op_valid, 1'b0);
        check_eq({tag, "_op_last"}, op_last, 1'b0);
        check_eq({tag, "_done"}, done, 1'b0);
        check_eq({tag, "_rf_rd_idx"}, rf_rd_idx, 0);
        check_eq({tag, "_op_idx"}, op_idx, 0);
        check_eq({tag, "_op_data"}, op_data, 0);
        check_eq({tag, "_op_sel"}, op_sel, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int sr_cnt;
        bit found;
        rst_n       = 1'b0;
        start_valid = 1'b0;
        start_vl    = '0;
        start_sel   = 3'b000;
        flush       = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_vals("post_reset");

        // Basic stream, full-speed lane.
        ready_mode = 0;
        do_start(4, 3'b010, 32'hA0, 0);
        wait_done(100);
        check_eq("t1_beats", beat_cnt, 4);
        check_eq("t1_reads", rd_cnt, 4);
        check_eq("t1_last_cnt", last_cnt, 1);
        check_eq("t1_done_lat", done_cyc - last_cyc, 1);
        check_eq("t1_start_ready", start_ready, 1'b1);
        @(negedge clk);
        #1;
        check_eq("t1_done_pulse", done, 1'b0);
        check_eq("t1_done_cnt", done_cnt, 1);

        // Zero-length op.
        do_start(0, 3'b001, 32'h0, 0);
        @(negedge clk);
        #1;
        check_eq("t2_done", done, 1'b1);
        repeat (4) @(negedge clk);
        #1;
        check_eq("t2_done_cnt", done_cnt, 1);
        check_eq("t2_reads", rd_cnt, 0);
        check_eq("t2_valid", valid_cnt, 0);

        // Lane stall: the buffer fills and reads stop.
        ready_mode = 2;
        stall_lo   = 1000000;
        do_start(8, 3'b100, 32'h50, 0);
        stall_lo = acc_cyc + 3;
        stall_hi = acc_cyc + 6;
        for (int i = 0; i < 20 && cyc != acc_cyc + 6; i++) @(negedge clk);
        #1;
        check_eq("t3_reads_in_stall", rd_cnt, 3);
        check_eq("t3_head_idx", op_idx, 1);
        check_eq("t3_head_valid", op_valid, 1'b1);
        wait_done(200);
        check_eq("t3_beats", beat_cnt, 8);
        check_eq("t3_reads", rd_cnt, 8);
        check_eq("t3_last_cnt", last_cnt, 1);
        ready_mode = 0;

        // Flush on the third handshake.
        do_start(6, 3'b101, 32'h100, 0);
        found = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (op_valid && op_idx == 2) begin
                flush = 1'b1;
                found = 1;
                break;
            end
        end
        check_eq("t4_flush_hit", found, 1);
        @(posedge clk);
        #1;
        flush = 1'b0;
        check_eq("t4_valid_after", op_valid, 1'b0);
        check_eq("t4_ready_after", start_ready, 1'b1);
        repeat (5) @(negedge clk);
        #1;
        check_eq("t4_no_done", done_cnt, 0);
        check_eq("t4_beats", beat_cnt, 3);
        do_start(2, 3'b011, 32'h200, 0);
        wait_done(100);
        check_eq("t4b_beats", beat_cnt, 2);
        check_eq("t4b_last_cnt", last_cnt, 1);

        // Asynchronous reset in the middle of an op.
        do_start(16, 3'b110, 32'h300, 0);
        found = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (op_valid && op_idx == 5) begin
                found = 1;
                break;
            end
        end
        check_eq("t5_idx5", found, 1);
        rst_n = 1'b0;
        #1;
        check_reset_vals("t5_midop");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("t5_start_ready", start_ready, 1'b1);
        check_eq("t5_no_done", done_cnt, 0);

        // Full-length op under random backpressure, next op queued on start_valid.
        ready_mode = 1;
        do_start(256, 3'b111, 32'h1000, 1);
        start_vl = 9'd3;
        sr_cnt = 0;
        found = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            #1;
            if (done) begin
                found = 1;
                break;
            end
            if (start_ready) sr_cnt++;
        end
        check_eq("t6_done_seen", found, 1);
        check_eq("t6_busy_ready", sr_cnt, 0);
        check_eq("t6_beats", beat_cnt, 256);
        check_eq("t6_reads", rd_cnt, 256);
        check_eq("t6_last_cnt", last_cnt, 1);
        check_eq("t6_done_cnt", done_cnt, 1);
        check_eq("t6_ready_at_done", start_ready, 1'b1);
        clear_sb(3, 3'b111, 32'h1000);
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        wait_done(200);
        check_eq("t6b_beats", beat_cnt, 3);
        check_eq("t6b_last_cnt", last_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
